// File: rtl/recovery_pkg.sv
// Shared types and defaults for the checkpoint/rollback sequencer.
package recovery_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned AW_DEF       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CKPT = 2'd1,
    ST_RSTR = 2'd2
  } rc_state_t;

  // Keep only the low 'aw' bits of an index so that the recovery register
  // address never carries stray upper bits.
  function automatic logic [31:0] zext_idx(input logic [31:0] idx, input int unsigned aw);
    logic [31:0] v;
    v = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < aw) v[b] = idx[b];
    end
    return v;
  endfunction

endpackage

// File: rtl/recovery_if.sv
// Copy-port bundle between the sequencer, the primary register file and the
// recovery register store.
interface recovery_if
  import recovery_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF
);

  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic            rf_we;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wd;
  logic            rec_WE;
  logic [31:0]     rec_A;
  logic [XLEN-1:0] rec_WD;
  logic [XLEN-1:0] rec_RD;

  modport master (
    output rf_rd_addr, rf_we, rf_wr_addr, rf_wd,
    output rec_WE, rec_A, rec_WD,
    input  rf_rd_data, rec_RD
  );

  modport slave (
    input  rf_rd_addr, rf_we, rf_wr_addr, rf_wd,
    input  rec_WE, rec_A, rec_WD,
    output rf_rd_data, rec_RD
  );

endinterface

// File: rtl/recovery_idx_counter.sv
// Register-walk index counter. One extra bit of width keeps the terminal
// compare from aliasing when NUM_REGS is a power of two.
module recovery_idx_counter
  import recovery_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned AW       = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_idx,
  output logic          o_last
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_REGS - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW:0] r_idx;

  // Clear has priority over advance; reset forces index 0.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= r_idx + ONE;
    end
  end

  assign o_idx  = r_idx[AW-1:0];
  assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/recovery_ctrl.sv
// Checkpoint/rollback sequencer: copies the register file and PC into the
// recovery store on request, and copies them back on a rollback request.
module recovery_ctrl
  import recovery_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned AW       = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            ckpt_req,
  input  logic            rstr_req,
  input  logic [XLEN-1:0] pc_in,
  recovery_if.master      bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            ckpt_valid,
  output logic [XLEN-1:0] restore_pc,
  output logic            pc_load
);

  rc_state_t       r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_pc_load;
  logic            r_ckpt_valid;
  logic [XLEN-1:0] r_saved_pc;
  logic [XLEN-1:0] r_restore_pc;

  logic [AW-1:0]   w_idx;
  logic            w_last;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic [31:0]     w_rec_a;

  // Counter is held at 0 while idle, so every walk starts from index 0;
  // an abort also clears it so no stale index leaks out.
  always_comb begin
    w_cnt_clr = (r_state == ST_IDLE) || ((r_state == ST_CKPT) && rstr_req);
    w_cnt_en  = (r_state != ST_IDLE);
  end

  recovery_idx_counter #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_idx (
    .clk    (clk),
    .rst_in (rst_in),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  assign w_rec_a = zext_idx(32'(w_idx), AW);

  // Sequencer FSM with registered status outputs; pulses default low.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_pc_load    <= 1'b0;
      r_ckpt_valid <= 1'b0;
      r_saved_pc   <= '0;
      r_restore_pc <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pc_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rstr_req) begin
            if (r_ckpt_valid) begin
              r_state <= ST_RSTR;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else if (ckpt_req) begin
            r_state      <= ST_CKPT;
            r_busy       <= 1'b1;
            r_saved_pc   <= pc_in;
            r_ckpt_valid <= 1'b0;
          end
        end
        ST_CKPT: begin
          // A rollback arriving mid-checkpoint finds the store half
          // overwritten, so the only safe answer is an unrecoverable error.
          if (rstr_req) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_err        <= 1'b1;
            r_ckpt_valid <= 1'b0;
          end else if (w_last) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_ckpt_valid <= 1'b1;
          end
        end
        ST_RSTR: begin
          if (w_last) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_pc_load    <= 1'b1;
            r_restore_pc <= r_saved_pc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Copy-port steering decoded from the state register; all zero when idle.
  always_comb begin
    bus.rf_rd_addr = '0;
    bus.rf_we      = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wd      = '0;
    bus.rec_WE     = 1'b0;
    bus.rec_A      = '0;
    bus.rec_WD     = '0;
    case (r_state)
      ST_CKPT: begin
        bus.rf_rd_addr = w_idx;
        bus.rec_A      = w_rec_a;
        bus.rec_WE     = 1'b1;
        bus.rec_WD     = bus.rf_rd_data;
      end
      ST_RSTR: begin
        bus.rec_A      = w_rec_a;
        bus.rf_wr_addr = w_idx;
        bus.rf_we      = 1'b1;
        bus.rf_wd      = bus.rec_RD;
      end
      default: begin
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign pc_load    = r_pc_load;
  assign ckpt_valid = r_ckpt_valid;
  assign restore_pc = r_restore_pc;

endmodule

// File: tb/tb_recovery_ctrl.sv
// Self-checking bench for recovery_ctrl: randomized operations checked
// against a transaction-level model of the register file and recovery store.
module tb_recovery_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam int INJ_NONE = 0;
  localparam int INJ_RSTR = 1;
  localparam int INJ_CKPT = 2;
  localparam int INJ_RST  = 3;

  logic            clk = 1'b0;
  logic            rst_in;
  logic            ckpt_req;
  logic            rstr_req;
  logic [XLEN-1:0] pc_in;
  logic            busy;
  logic            done;
  logic            err;
  logic            ckpt_valid;
  logic [XLEN-1:0] restore_pc;
  logic            pc_load;

  recovery_if #(.XLEN(XLEN), .AW(AW)) bus ();

  recovery_ctrl #(
    .XLEN     (XLEN),
    .NUM_REGS (NREG),
    .AW       (AW)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .ckpt_req   (ckpt_req),
    .rstr_req   (rstr_req),
    .pc_in      (pc_in),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ckpt_valid (ckpt_valid),
    .restore_pc (restore_pc),
    .pc_load    (pc_load)
  );

  always #5 clk = ~clk;

  // Environment memories: primary register file and recovery store.
  logic [XLEN-1:0] rf      [NREG];
  logic [XLEN-1:0] rec     [NREG];
  logic [XLEN-1:0] bd_vals [NREG];
  logic            bd_fill = 1'b0;
  logic            bd_init = 1'b0;

  assign bus.rf_rd_data = rf[bus.rf_rd_addr];
  assign bus.rec_RD     = rec[bus.rec_A[AW-1:0]];

  // Memory write ports plus a backdoor used to load register file contents.
  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < NREG; i++) rf[i] <= bd_vals[i];
    end else if (bus.rf_we) begin
      rf[bus.rf_wr_addr] <= bus.rf_wd;
    end
    if (bd_init) begin
      for (int i = 0; i < NREG; i++) rec[i] <= '0;
    end else if (bus.rec_WE) begin
      rec[bus.rec_A[AW-1:0]] <= bus.rec_WD;
    end
  end

  // Reference model state.
  logic [XLEN-1:0] mrf  [NREG];
  logic [XLEN-1:0] mrec [NREG];
  logic [XLEN-1:0] mpc;
  bit              mvalid;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy, done, err, pc_load, ckpt_valid, bus.rec_WE, bus.rf_we}), 32'd0);
    chk({tag, "_rpc"}, restore_pc, 32'd0);
    chk({tag, "_recA"}, bus.rec_A, 32'd0);
    chk({tag, "_rfad"}, 32'({bus.rf_rd_addr, bus.rf_wr_addr}), 32'd0);
  endtask

  // kind 0: x[i]=i*3, 1: all 0xDEADBEEF, 2: random
  task automatic fill(input int kind, input bit clear_rec);
    logic [XLEN-1:0] v;
    for (int i = 0; i < NREG; i++) begin
      case (kind)
        0:       v = 32'(i * 3);
        1:       v = 32'hDEAD_BEEF;
        default: v = $urandom;
      endcase
      bd_vals[i] = v;
      mrf[i]     = v;
      if (clear_rec) mrec[i] = '0;
    end
    bd_fill = 1'b1;
    bd_init = clear_rec;
    @(negedge clk);
    bd_fill = 1'b0;
    bd_init = 1'b0;
  endtask

  // One operation: request pulse, optional disturbance at observation cycle
  // inj_at (cycle 1 = first cycle after the request edge), then a fixed
  // observation window and a full memory comparison.
  task automatic run_op(input bit ck, input bit rs, input int inj_kind_in,
                        input int inj_at, input logic [XLEN-1:0] pc);
    int mode;  // 0 rejected, 1 checkpoint, 2 restore
    int inj_kind, n_exp, done_exp, err_exp, rst_at, busy_exp;
    bit valid_exp;
    logic [XLEN-1:0] pc_exp;
    int nrec, nrf, nboth, nbad, nbusy, ndone, done_at, nerr, err_at, npcl, pcl_at;

    mode      = rs ? (mvalid ? 2 : 0) : 1;
    inj_kind  = (mode == 0) ? INJ_NONE : inj_kind_in;
    n_exp     = (mode == 0) ? 0 : NREG;
    done_exp  = (mode == 0) ? 0 : NREG + 1;
    err_exp   = (mode == 0) ? 1 : 0;
    rst_at    = 0;
    valid_exp = (mode == 1) ? 1'b1 : mvalid;
    if (mode == 1 && inj_kind == INJ_RSTR) begin
      n_exp = inj_at; done_exp = 0; err_exp = inj_at + 1; valid_exp = 1'b0;
    end
    if (inj_kind == INJ_RST) begin
      n_exp = inj_at; done_exp = 0; rst_at = inj_at + 1; valid_exp = 1'b0;
    end
    busy_exp = n_exp;
    pc_exp   = mpc;

    nrec = 0; nrf = 0; nboth = 0; nbad = 0; nbusy = 0; ndone = 0; done_at = 0;
    nerr = 0; err_at = 0; npcl = 0; pcl_at = 0;

    pc_in    = pc;
    ckpt_req = ck;
    rstr_req = rs;
    @(negedge clk);
    pc_in = $urandom;
    for (int j = 1; j <= 36; j++) begin
      ckpt_req = 1'b0;
      rstr_req = 1'b0;
      rst_in   = 1'b1;
      if (bus.rec_WE) begin
        chk("ck_recA", bus.rec_A, 32'(nrec));
        chk("ck_rdad", 32'(bus.rf_rd_addr), 32'(nrec));
        chk("ck_recWD", bus.rec_WD, mrf[nrec % NREG]);
        nrec++;
      end
      if (bus.rf_we) begin
        chk("rs_wrad", 32'(bus.rf_wr_addr), 32'(nrf));
        chk("rs_recA", bus.rec_A, 32'(nrf));
        chk("rs_wd", bus.rf_wd, mrec[nrf % NREG]);
        nrf++;
      end
      if (bus.rec_WE && bus.rf_we) nboth++;
      if (!busy && (bus.rec_WE || bus.rf_we || bus.rec_A != 0 ||
                    bus.rf_rd_addr != 0 || bus.rf_wr_addr != 0)) nbad++;
      if (busy && !(bus.rec_WE || bus.rf_we)) nbad++;
      if (busy) nbusy++;
      if (done) begin ndone++; done_at = j; end
      if (err) begin nerr++; err_at = j; end
      if (pc_load) begin
        npcl++; pcl_at = j;
        chk("restore_pc", restore_pc, pc_exp);
      end
      if (j == rst_at) chk_zero("mid_reset");
      if (j == inj_at) begin
        case (inj_kind)
          INJ_RSTR: rstr_req = 1'b1;
          INJ_CKPT: ckpt_req = 1'b1;
          INJ_RST:  rst_in   = 1'b0;
          default:  ;
        endcase
      end
      @(negedge clk);
    end
    ckpt_req = 1'b0;
    rstr_req = 1'b0;
    rst_in   = 1'b1;

    chk("n_rec_we", 32'(nrec), 32'((mode == 1) ? n_exp : 0));
    chk("n_rf_we", 32'(nrf), 32'((mode == 2) ? n_exp : 0));
    chk("we_both", 32'(nboth), 32'd0);
    chk("idle_bus", 32'(nbad), 32'd0);
    chk("n_busy", 32'(nbusy), 32'(busy_exp));
    chk("n_done", 32'(ndone), 32'((done_exp != 0) ? 1 : 0));
    chk("done_at", 32'(done_at), 32'(done_exp));
    chk("n_err", 32'(nerr), 32'((err_exp != 0) ? 1 : 0));
    chk("err_at", 32'(err_at), 32'(err_exp));
    chk("n_pcload", 32'(npcl), 32'((mode == 2 && done_exp != 0) ? 1 : 0));
    chk("pcl_at", 32'(pcl_at), 32'((mode == 2) ? done_exp : 0));
    chk("ckpt_valid", 32'(ckpt_valid), 32'(valid_exp));

    if (mode == 1) begin
      for (int i = 0; i < n_exp; i++) mrec[i] = mrf[i];
      mpc = pc;
    end else if (mode == 2) begin
      for (int i = 0; i < n_exp; i++) mrf[i] = mrec[i];
    end
    mvalid = valid_exp;

    for (int i = 0; i < NREG; i++) begin
      chk("rf_mem", rf[i], mrf[i]);
      chk("rec_mem", rec[i], mrec[i]);
    end
  endtask

  initial begin
    bit ck, rs;
    rst_in   = 1'b0;
    ckpt_req = 1'b0;
    rstr_req = 1'b0;
    pc_in    = '0;
    mpc      = '0;
    mvalid   = 1'b0;
    @(negedge clk);
    fill(0, 1'b1);
    @(negedge clk);
    chk_zero("reset");
    rst_in = 1'b1;
    @(negedge clk);

    run_op(1'b0, 1'b1, INJ_NONE, 0, 32'h0);
    fill(0, 1'b0);
    run_op(1'b1, 1'b0, INJ_NONE, 0, 32'h100);
    fill(1, 1'b0);
    run_op(1'b0, 1'b1, INJ_NONE, 0, 32'h200);
    run_op(1'b0, 1'b1, INJ_NONE, 0, 32'h300);
    run_op(1'b1, 1'b0, INJ_RSTR, 10, 32'h400);
    run_op(1'b0, 1'b1, INJ_NONE, 0, 32'h0);
    run_op(1'b1, 1'b0, INJ_NONE, 0, 32'h500);
    fill(1, 1'b0);
    run_op(1'b1, 1'b1, INJ_CKPT, 5, 32'h600);
    run_op(1'b0, 1'b1, INJ_RST, 5, 32'h0);
    run_op(1'b0, 1'b1, INJ_NONE, 0, 32'h0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) fill(2, 1'b0);
      ck = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (!ck && !rs) ck = 1'b1;
      run_op(ck, rs, int'($urandom_range(0, 3)), int'($urandom_range(1, 32)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
